// File: rtl/uart_tx_frame_sender_if.sv
// Pixel valid/ready handshake between the image pipeline
// and the UART frame sender.
interface uart_tx_frame_sender_if #(
   parameter int DATA_WIDTH = 8
);
   logic [3*DATA_WIDTH-1:0] rgb_data;
   logic                    pixel_valid;
   logic                    pixel_ready;

   modport master (
      output rgb_data,
      output pixel_valid,
      input  pixel_ready
   );

   modport slave (
      input  rgb_data,
      input  pixel_valid,
      output pixel_ready
   );
endinterface

// File: rtl/uart_tx_frame_sender.sv
// RGB pixel -> 3 UART bytes (R,G,B) through a tagged FIFO.
// Define UART_TX_PARITY_EN for 8E1 frames (default 8N1).
module uart_tx_frame_sender #(
   parameter int DATA_WIDTH      = 8,
   parameter int FIFO_ADDR_WIDTH = 5,
   parameter int CLK_FREQ        = 100_000_000,
   parameter int BAUD_RATE       = 115200,
   parameter int BAUD_DIV        = CLK_FREQ / BAUD_RATE,
   parameter int IMG_WIDTH       = 80,
   parameter int IMG_HEIGHT      = 120,
   parameter int TOTAL_PIXELS    = IMG_WIDTH * IMG_HEIGHT,
   parameter int PIXEL_CNT_WIDTH = $clog2(TOTAL_PIXELS)
) (
   input  logic                       clk,
   input  logic                       reset,
   uart_tx_frame_sender_if.slave      pix,
   output logic                       tx,
   output logic                       tx_busy,
   output logic                       tx_done,
   output logic [PIXEL_CNT_WIDTH-1:0] pixel_cnt,
   output logic                       frame_done
);
   localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
   localparam int CW = FIFO_ADDR_WIDTH + 1;
   localparam int BW = $clog2(BAUD_DIV);
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [IW-1:0] BIT_LAST = IW'(DATA_WIDTH - 1);
   localparam logic [PIXEL_CNT_WIDTH-1:0] CNT_LAST =
      PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1);

   typedef enum logic [1:0] {
      D_IDLE, D_PUSH_R, D_PUSH_G, D_PUSH_B
   } dis_t;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } ser_t;

`ifdef UART_TX_PARITY_EN
   localparam ser_t AFTER_DATA = S_PARITY;
`else
   localparam ser_t AFTER_DATA = S_STOP;
`endif

   dis_t dis_q, dis_d;
   ser_t ser_q, ser_d;

   logic [3*DATA_WIDTH-1:0] pixel_q;
   logic                    last_q;
   logic                    accept;

   logic                     fifo_wr, fifo_rd;
   logic                     fifo_full, fifo_empty;
   logic [DATA_WIDTH:0]      fifo_din, fifo_dout;
   logic [DATA_WIDTH:0]      mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]            count;

   logic [BW-1:0]         baud_q;
   logic [IW-1:0]         bit_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  tag_q;
   logic                  tick;
   logic                  line_d;
`ifdef UART_TX_PARITY_EN
   logic                  par_q;
`endif

   assign pix.pixel_ready = (dis_q == D_IDLE);
   assign accept = pix.pixel_valid && pix.pixel_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dis_q     <= D_IDLE;
         pixel_q   <= '0;
         last_q    <= 1'b0;
         pixel_cnt <= '0;
      end else begin
         dis_q <= dis_d;
         if (accept) begin
            pixel_q   <= pix.rgb_data;
            last_q    <= (pixel_cnt == CNT_LAST);
            pixel_cnt <= (pixel_cnt == CNT_LAST) ?
                         '0 : pixel_cnt + 1'b1;
         end
      end
   end

   // Each push stage holds while the FIFO is full.
   always_comb begin
      dis_d    = dis_q;
      fifo_wr  = 1'b0;
      fifo_din = '0;
      unique case (dis_q)
         D_IDLE: begin
            if (accept) dis_d = D_PUSH_R;
         end
         D_PUSH_R: begin
            fifo_din = {1'b0, pixel_q[3*DATA_WIDTH-1 -: DATA_WIDTH]};
            fifo_wr  = !fifo_full;
            if (!fifo_full) dis_d = D_PUSH_G;
         end
         D_PUSH_G: begin
            fifo_din = {1'b0, pixel_q[2*DATA_WIDTH-1 -: DATA_WIDTH]};
            fifo_wr  = !fifo_full;
            if (!fifo_full) dis_d = D_PUSH_B;
         end
         D_PUSH_B: begin
            fifo_din = {last_q, pixel_q[DATA_WIDTH-1:0]};
            fifo_wr  = !fifo_full;
            if (!fifo_full) dis_d = D_IDLE;
         end
      endcase
   end

   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   assign fifo_dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
         unique case ({fifo_wr, fifo_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr] <= fifo_din;
   end

   assign tick = (baud_q == BAUD_LAST);

   always_comb begin
      ser_d   = ser_q;
      fifo_rd = 1'b0;
      line_d  = 1'b1;
      unique case (ser_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               ser_d   = S_START;
            end
         end
         S_START: begin
            line_d = 1'b0;
            if (tick) ser_d = S_DATA;
         end
         S_DATA: begin
            line_d = shift_q[0];
            if (tick && bit_q == BIT_LAST) ser_d = AFTER_DATA;
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            line_d = par_q;
            if (tick) ser_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (tick) begin
               fifo_rd = !fifo_empty;
               ser_d   = fifo_empty ? S_IDLE : S_START;
            end
         end
         default: ser_d = S_IDLE;
      endcase
   end

   // tx is registered from the current state, so the line
   // trails the serializer state by one clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ser_q      <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tag_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
         tx         <= 1'b1;
         tx_done    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         ser_q      <= ser_d;
         tx         <= line_d;
         tx_done    <= (ser_q == S_STOP) && tick;
         frame_done <= (ser_q == S_STOP) && tick && tag_q;
         baud_q     <= (ser_d != ser_q || tick) ?
                       '0 : baud_q + 1'b1;
         if (fifo_rd) begin
            shift_q <= fifo_dout[DATA_WIDTH-1:0];
            tag_q   <= fifo_dout[DATA_WIDTH];
`ifdef UART_TX_PARITY_EN
            par_q   <= ^fifo_dout[DATA_WIDTH-1:0];
`endif
            bit_q   <= '0;
         end else if (ser_q == S_DATA && tick) begin
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 1'b1;
         end
      end
   end

   assign tx_busy = (dis_q != D_IDLE) || !fifo_empty ||
                    (ser_q != S_IDLE);
endmodule

// File: tb/tb_uart_tx_frame_sender.sv
// Scoreboard bench: a line monitor decodes tx into bytes and
// compares them against bytes queued at pixel acceptance.
module tb_uart_tx_frame_sender;
   localparam int BD = 10;
   localparam int TOTAL = 4;
`ifdef UART_TX_PARITY_EN
   localparam int BITS = 11;
`else
   localparam int BITS = 10;
`endif
   localparam int FRAME = BITS * BD;

   typedef struct {
      logic [7:0] data;
      logic       start_ok;
      logic       bit9;
      logic       stop_ok;
      int         start_cyc;
   } rx_t;

   typedef struct {
      int   cyc;
      logic frame;
   } done_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tx, tx_busy, tx_done, frame_done;
   logic [1:0] pixel_cnt;

   uart_tx_frame_sender_if #(.DATA_WIDTH(8)) pi ();

   uart_tx_frame_sender #(
      .DATA_WIDTH(8),
      .FIFO_ADDR_WIDTH(2),
      .CLK_FREQ(1_000_000),
      .BAUD_RATE(100_000),
      .IMG_WIDTH(2),
      .IMG_HEIGHT(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pix(pi.slave),
      .tx(tx),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .pixel_cnt(pixel_cnt),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   rx_t   rx_q[$];
   done_t done_q[$];
   exp_t  exp_q[$];
   int    fd_total = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cnt_model = 0;

   logic mon_on = 1'b0;
   int   mon_cnt = 0;
   rx_t  mon_rec;

   always @(negedge clk) begin
      int k;
      if (reset !== 1'b1) begin
         mon_on = 1'b0;
      end else if (!mon_on) begin
         if (tx === 1'b0) begin
            mon_on = 1'b1;
            mon_cnt = 0;
            mon_rec.start_cyc = cyc;
            mon_rec.start_ok = 1'b1;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % BD == BD / 2) begin
            k = mon_cnt / BD;
            if (k == 0) mon_rec.start_ok = (tx === 1'b0);
            else if (k <= 8) mon_rec.data[k-1] = tx;
            if (k == 9) mon_rec.bit9 = tx;
            if (k == BITS - 1) begin
               mon_rec.stop_ok = (tx === 1'b1);
               rx_q.push_back(mon_rec);
               mon_on = 1'b0;
            end
         end
      end
      if (reset === 1'b1 && tx_done === 1'b1)
         done_q.push_back('{cyc, frame_done});
      if (reset === 1'b1 && frame_done === 1'b1)
         fd_total++;
   end

   task automatic apply_reset();
      pi.pixel_valid = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      cnt_model = 0;
      exp_q.delete();
   endtask

   // Entered on a negedge; returns on the negedge after acceptance.
   task automatic send_pixel(input logic [23:0] px,
                             output int acc, output logic ok);
      int t;
      logic last;
      t = 0;
      pi.rgb_data = px;
      pi.pixel_valid = 1'b1;
      while (pi.pixel_ready !== 1'b1 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      ok = (pi.pixel_ready === 1'b1);
      @(posedge clk);
      last = (cnt_model == TOTAL - 1);
      exp_q.push_back('{px[23:16], 1'b0});
      exp_q.push_back('{px[15:8], 1'b0});
      exp_q.push_back('{px[7:0], last});
      cnt_model = last ? 0 : cnt_model + 1;
      @(negedge clk);
      acc = cyc;
   endtask

   task automatic wait_out(input int rt, input int dt, input int lim);
      for (int t = 0; t < lim; t++) begin
         if (rx_q.size() >= rt && done_q.size() >= dt) break;
         @(negedge clk);
      end
      repeat (BD * 2) @(negedge clk);
   endtask

   task automatic test_reset();
      pi.pixel_valid = 1'b0;
      pi.rgb_data = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1) begin
         n_bad++; $display("FAIL reset_tx: got %b want 1", tx);
      end
      n_cmp++;
      if (pi.pixel_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_ready: got %b want 1", pi.pixel_ready);
      end
      n_cmp++;
      if (tx_busy !== 1'b0) begin
         n_bad++; $display("FAIL reset_busy: got %b want 0", tx_busy);
      end
      n_cmp++;
      if (tx_done !== 1'b0 || frame_done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_pulses: got %b%b want 00",
                  tx_done, frame_done);
      end
      n_cmp++;
      if (pixel_cnt !== 2'd0) begin
         n_bad++; $display("FAIL reset_cnt: got %0d want 0", pixel_cnt);
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_idle: got tx %b busy %b want 1 0",
                  tx, tx_busy);
      end
   endtask

   task automatic test_single_pixel();
      int acc, rb, db, n;
      logic ok, want;
      exp_t e;
      apply_reset();
      rb = rx_q.size();
      db = done_q.size();
      send_pixel(24'hA53C0F, acc, ok);
      pi.pixel_valid = 1'b0;
      n_cmp++;
      if (ok !== 1'b1) begin
         n_bad++; $display("FAIL single_accept: got %b want 1", ok);
      end
      for (int i = 0; i < 4; i++) begin
         want = (i < 3);
         n_cmp++;
         if (tx !== want) begin
            n_bad++;
            $display("FAIL single_tx_fall_%0d: got %b want %b",
                     i, tx, want);
         end
         @(negedge clk);
      end
      wait_out(rb + 3, db + 3, 3 * FRAME + 100);
      n_cmp++;
      if (rx_q.size() != rb + 3 || done_q.size() != db + 3) begin
         n_bad++;
         $display("FAIL single_count: got %0d bytes %0d dones want 3 3",
                  rx_q.size() - rb, done_q.size() - db);
      end
      n = rx_q.size() - rb;
      if (done_q.size() - db < n) n = done_q.size() - db;
      if (n > 3) n = 3;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rx_q[rb+i].data !== e.data || !rx_q[rb+i].start_ok ||
             !rx_q[rb+i].stop_ok) begin
            n_bad++;
            $display("FAIL single_byte%0d: got %h st %b sp %b want %h",
                     i, rx_q[rb+i].data, rx_q[rb+i].start_ok,
                     rx_q[rb+i].stop_ok, e.data);
         end
         n_cmp++;
         if (done_q[db+i].frame !== e.last) begin
            n_bad++;
            $display("FAIL single_frame%0d: got %b want %b",
                     i, done_q[db+i].frame, e.last);
         end
      end
      if (n >= 1) begin
         n_cmp++;
         if (done_q[db].cyc - acc != 2 + FRAME) begin
            n_bad++;
            $display("FAIL single_first_done: got %0d want %0d",
                     done_q[db].cyc - acc, 2 + FRAME);
         end
      end
      for (int i = 1; i < n; i++) begin
         n_cmp++;
         if (done_q[db+i].cyc - done_q[db+i-1].cyc != FRAME) begin
            n_bad++;
            $display("FAIL single_done_gap%0d: got %0d want %0d", i,
                     done_q[db+i].cyc - done_q[db+i-1].cyc, FRAME);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] px [4];
      int cnt_exp [4];
      int acc, rb, db, fb, n;
      logic ok;
      exp_t e;
      px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
      cnt_exp = '{1, 2, 3, 0};
      apply_reset();
      rb = rx_q.size();
      db = done_q.size();
      fb = fd_total;
      for (int i = 0; i < 4; i++) begin
         send_pixel(px[i], acc, ok);
         n_cmp++;
         if (ok !== 1'b1 || pixel_cnt !== 2'(cnt_exp[i])) begin
            n_bad++;
            $display("FAIL b2b_cnt%0d: got %0d ok %b want %0d",
                     i, pixel_cnt, ok, cnt_exp[i]);
         end
      end
      pi.pixel_valid = 1'b0;
      wait_out(rb + 12, db + 12, 12 * FRAME + 200);
      n_cmp++;
      if (rx_q.size() != rb + 12 || done_q.size() != db + 12) begin
         n_bad++;
         $display("FAIL b2b_count: got %0d bytes %0d dones want 12 12",
                  rx_q.size() - rb, done_q.size() - db);
      end
      n = rx_q.size() - rb;
      if (done_q.size() - db < n) n = done_q.size() - db;
      if (n > 12) n = 12;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rx_q[rb+i].data !== e.data || !rx_q[rb+i].stop_ok ||
             done_q[db+i].frame !== e.last) begin
            n_bad++;
            $display("FAIL b2b_byte%0d: got %h fd %b want %h fd %b", i,
                     rx_q[rb+i].data, done_q[db+i].frame,
                     e.data, e.last);
         end
         if (i > 0) begin
            n_cmp++;
            if (rx_q[rb+i].start_cyc - rx_q[rb+i-1].start_cyc
                != FRAME) begin
               n_bad++;
               $display("FAIL b2b_gap%0d: got %0d want %0d", i,
                        rx_q[rb+i].start_cyc - rx_q[rb+i-1].start_cyc,
                        FRAME);
            end
         end
      end
      n_cmp++;
      if (fd_total - fb != 1) begin
         n_bad++;
         $display("FAIL b2b_frame_done_count: got %0d want 1",
                  fd_total - fb);
      end
   endtask

   task automatic test_fifo_stall();
      int acc, prev, gap, max_gap, rb, db, fb, n;
      logic ok, all_ok;
      exp_t e;
      apply_reset();
      rb = rx_q.size();
      db = done_q.size();
      fb = fd_total;
      max_gap = 0;
      all_ok = 1'b1;
      prev = cyc;
      for (int i = 0; i < 12; i++) begin
         send_pixel(24'($urandom), acc, ok);
         all_ok = all_ok & ok;
         gap = acc - prev;
         if (i > 0 && gap > max_gap) max_gap = gap;
         prev = acc;
      end
      pi.pixel_valid = 1'b0;
      n_cmp++;
      if (all_ok !== 1'b1) begin
         n_bad++; $display("FAIL stall_accept: got %b want 1", all_ok);
      end
      n_cmp++;
      if (max_gap <= 4) begin
         n_bad++;
         $display("FAIL stall_ready: got max gap %0d want >4", max_gap);
      end
      wait_out(rb + 36, db + 36, 36 * FRAME + 400);
      n_cmp++;
      if (rx_q.size() != rb + 36 || done_q.size() != db + 36) begin
         n_bad++;
         $display("FAIL stall_count: got %0d bytes %0d dones want 36",
                  rx_q.size() - rb, done_q.size() - db);
      end
      n = rx_q.size() - rb;
      if (done_q.size() - db < n) n = done_q.size() - db;
      if (n > 36) n = 36;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rx_q[rb+i].data !== e.data ||
             done_q[db+i].frame !== e.last) begin
            n_bad++;
            $display("FAIL stall_byte%0d: got %h fd %b want %h fd %b", i,
                     rx_q[rb+i].data, done_q[db+i].frame,
                     e.data, e.last);
         end
      end
      n_cmp++;
      if (fd_total - fb != 3) begin
         n_bad++;
         $display("FAIL stall_frames: got %0d want 3", fd_total - fb);
      end
   endtask

   task automatic test_reset_mid_byte();
      int acc, rb, db, n;
      logic ok;
      exp_t e;
      apply_reset();
      rb = rx_q.size();
      db = done_q.size();
      send_pixel(24'hC30081, acc, ok);
      pi.pixel_valid = 1'b0;
      for (int t = 0; t < 2 * FRAME; t++) begin
         if (done_q.size() >= db + 1) break;
         @(negedge clk);
      end
      repeat (2 + 4 * BD + 5) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b0 || tx_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_pre: got tx %b busy %b want 0 1",
                  tx, tx_busy);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || pixel_cnt !== 2'd0) begin
         n_bad++;
         $display("FAIL mid_abort: got tx %b busy %b cnt %0d want 1 0 0",
                  tx, tx_busy, pixel_cnt);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (rx_q.size() < rb + 1 || rx_q[rb].data !== e.data) begin
         n_bad++;
         $display("FAIL mid_first_byte: got %0d bytes want %h",
                  rx_q.size() - rb, e.data);
      end
      exp_q.delete();
      cnt_model = 0;
      repeat (2 * FRAME) @(negedge clk);
      n_cmp++;
      if (rx_q.size() != rb + 1 || done_q.size() != db + 1) begin
         n_bad++;
         $display("FAIL mid_discard: got %0d bytes %0d dones want 1 1",
                  rx_q.size() - rb, done_q.size() - db);
      end
      rb = rx_q.size();
      db = done_q.size();
      send_pixel(24'h123456, acc, ok);
      pi.pixel_valid = 1'b0;
      n_cmp++;
      if (ok !== 1'b1 || pixel_cnt !== 2'd1) begin
         n_bad++;
         $display("FAIL mid_restart_cnt: got %0d ok %b want 1",
                  pixel_cnt, ok);
      end
      wait_out(rb + 3, db + 3, 3 * FRAME + 100);
      n = rx_q.size() - rb;
      n_cmp++;
      if (n != 3) begin
         n_bad++; $display("FAIL mid_restart_count: got %0d want 3", n);
      end
      if (n > 3) n = 3;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (rx_q[rb+i].data !== e.data || !rx_q[rb+i].stop_ok) begin
            n_bad++;
            $display("FAIL mid_restart_byte%0d: got %h want %h",
                     i, rx_q[rb+i].data, e.data);
         end
      end
   endtask

   task automatic test_parity();
      int acc, rb, db, n;
      logic ok, want;
      exp_t e;
      apply_reset();
      rb = rx_q.size();
      db = done_q.size();
      send_pixel(24'h070300, acc, ok);
      pi.pixel_valid = 1'b0;
      wait_out(rb + 3, db + 3, 3 * FRAME + 100);
      n = rx_q.size() - rb;
      if (done_q.size() - db < n) n = done_q.size() - db;
      n_cmp++;
      if (n != 3) begin
         n_bad++; $display("FAIL par_count: got %0d want 3", n);
      end
      if (n > 3) n = 3;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
         want = ^e.data;
`else
         want = 1'b1;
`endif
         n_cmp++;
         if (rx_q[rb+i].data !== e.data || rx_q[rb+i].bit9 !== want ||
             !rx_q[rb+i].stop_ok) begin
            n_bad++;
            $display("FAIL par_byte%0d: got %h bit9 %b want %h bit9 %b",
                     i, rx_q[rb+i].data, rx_q[rb+i].bit9, e.data, want);
         end
         if (i > 0) begin
            n_cmp++;
            if (done_q[db+i].cyc - done_q[db+i-1].cyc != FRAME) begin
               n_bad++;
               $display("FAIL par_len%0d: got %0d want %0d", i,
                        done_q[db+i].cyc - done_q[db+i-1].cyc, FRAME);
            end
         end
      end
   endtask

   initial begin
      pi.rgb_data = '0;
      pi.pixel_valid = 1'b0;
      test_reset();
      test_single_pixel();
      test_back_to_back();
      test_fifo_stall();
      test_reset_mid_byte();
      test_parity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
